lm32_tlb_refill: RTL and testbench

- Hardware refill engine that services TLB misses.
- Takes a faulting virtual address and walks a single-level page table in memory through a Wishbone master (read-only).
- On a valid PTE, programs the TLB through the same CSR write path software uses: a TLBVADDR write followed by a TLBPADDR write, which triggers the TLB update.
- Sits between the I/D TLB miss outputs, the data bus arbiter and the CPU CSR write mux.

---
 rtl/lm32_tlb_refill.sv | 132 +++++++++++++
 tb/tb_lm32_tlb_refill.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/lm32_tlb_refill.sv
// Hardware TLB refill engine: fetches one PTE over a read-only Wishbone master
// and programs the TLB through the CSR write port (TLBVADDR, then TLBPADDR).
module lm32_tlb_refill #(
  parameter int page_size      = 4096,
  parameter int timeout_cycles = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        miss_i,
  input  logic [31:0] miss_addr_i,
  input  logic [31:0] ptbr_i,
  input  logic        cpu_csr_we_i,
  output logic [31:0] wb_adr_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic [4:0]  tlb_csr_o,
  output logic [31:0] tlb_csr_data_o,
  output logic        tlb_csr_we_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        fault_o,
  output logic [31:0] fault_addr_o
);

  localparam int off_w = $clog2(page_size);
  localparam logic [4:0] csr_tlbvaddr = 5'h1e;
  localparam logic [4:0] csr_tlbpaddr = 5'h1f;
  localparam logic [7:0] tmo_last     = 8'(timeout_cycles - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, WR_VADDR, WR_PADDR, DONE, FAULT
  } state_t;

  state_t            state, state_next;
  logic              armed;
  logic [7:0]        tmo_cnt;
  logic [31:off_w]   pfn;
  logic [31:0]       pte_addr;
  logic              accept, pte_ok;
  logic              unused_bits;

  // Word-aligned table base plus VPN*4; the 32-bit sum wraps on overflow.
  assign pte_addr    = {ptbr_i[31:2], 2'b00} + 32'({miss_addr_i[31:off_w], 2'b00});
  assign unused_bits = ^{wb_dat_i[off_w-1:1], ptbr_i[1:0], miss_addr_i[off_w-1:0]};

  assign wb_cyc_o = (state == FETCH);
  assign wb_stb_o = (state == FETCH);
  assign wb_sel_o = 4'hF;
  assign busy_o   = (state != IDLE);
  assign done_o   = (state == DONE);
  assign fault_o  = (state == FAULT);

  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    pte_ok       = 1'b0;
    tlb_csr_we_o = 1'b0;
    case (state)
      IDLE: begin
        if (miss_i && armed) begin
          accept     = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: begin
        // Error beats a simultaneous ack; a late ack still beats the timeout.
        if (wb_err_i || (wb_ack_i && !wb_dat_i[0])) begin
          state_next = FAULT;
        end else if (wb_ack_i) begin
          pte_ok     = 1'b1;
          state_next = WR_VADDR;
        end else if (tmo_cnt == tmo_last) begin
          state_next = FAULT;
        end
      end
      WR_VADDR: begin
        if (!cpu_csr_we_i) begin
          tlb_csr_we_o = 1'b1;
          state_next   = WR_PADDR;
        end
      end
      WR_PADDR: begin
        if (!cpu_csr_we_i) begin
          tlb_csr_we_o = 1'b1;
          state_next   = DONE;
        end
      end
      DONE:    state_next = IDLE;
      FAULT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      armed          <= 1'b1;
      tmo_cnt        <= '0;
      pfn            <= '0;
      wb_adr_o       <= '0;
      fault_addr_o   <= '0;
      tlb_csr_o      <= '0;
      tlb_csr_data_o <= '0;
    end else begin
      state <= state_next;
      // A miss still held after its walk must drop before it can be taken again.
      if (accept) begin
        armed        <= 1'b0;
        fault_addr_o <= miss_addr_i;
        wb_adr_o     <= pte_addr;
        tmo_cnt      <= '0;
      end else if (state == IDLE && !miss_i) begin
        armed <= 1'b1;
      end
      if (state == FETCH) tmo_cnt <= tmo_cnt + 8'd1;
      if (pte_ok) begin
        pfn            <= wb_dat_i[31:off_w];
        tlb_csr_o      <= csr_tlbvaddr;
        tlb_csr_data_o <= {fault_addr_o[31:off_w], {off_w{1'b0}}};
      end
      if (state == WR_VADDR && tlb_csr_we_o) begin
        tlb_csr_o      <= csr_tlbpaddr;
        tlb_csr_data_o <= {pfn, {off_w{1'b0}}};
      end
    end
  end

endmodule

// File: tb/tb_lm32_tlb_refill.sv
// Directed and randomized refill walks checked against an arithmetic model of
// the expected bus address, CSR write schedule and completion/fault timing.
module tb_lm32_tlb_refill;

  localparam int          OFF   = 12;
  localparam int          TMO   = 255;
  localparam logic [31:0] CSR_V = 32'h1e;
  localparam logic [31:0] CSR_P = 32'h1f;
  localparam int M_ACK = 0, M_ERR = 1, M_NONE = 2, M_BOTH = 3;

  logic        clk = 1'b0;
  logic        rst_i, miss_i, cpu_csr_we_i, wb_ack_i, wb_err_i;
  logic [31:0] miss_addr_i, ptbr_i, wb_dat_i;
  logic [31:0] wb_adr_o, tlb_csr_data_o, fault_addr_o;
  logic        wb_cyc_o, wb_stb_o, tlb_csr_we_o, busy_o, done_o, fault_o;
  logic [3:0]  wb_sel_o;
  logic [4:0]  tlb_csr_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lm32_tlb_refill dut (
    .clk_i(clk), .rst_i(rst_i), .miss_i(miss_i), .miss_addr_i(miss_addr_i),
    .ptbr_i(ptbr_i), .cpu_csr_we_i(cpu_csr_we_i), .wb_adr_o(wb_adr_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .tlb_csr_o(tlb_csr_o), .tlb_csr_data_o(tlb_csr_data_o),
    .tlb_csr_we_o(tlb_csr_we_o), .busy_o(busy_o), .done_o(done_o),
    .fault_o(fault_o), .fault_addr_o(fault_addr_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one walk, playing the memory and the CPU CSR writer, then compares
  // what happened with the expected schedule.
  task automatic run_walk(input string tag, input logic [31:0] va, input logic [31:0] pt,
                          input logic [31:0] pte, input int mode, input int delay,
                          input int stall, input bit keep_miss);
    int c = 0, stb_n = 0, first_stb = -1, ack_c = -100, stalls = stall;
    int nwr = 0, n_done = 0, n_fault = 0, done_c = -1, fault_c = -1, overlap = 0;
    logic [31:0] wr_csr[2], wr_dat[2];
    int          wr_c[2];
    logic [31:0] seen_adr = 32'hx;
    logic [31:0] exp_adr;
    bit fin = 1'b0, ok;
    wr_csr[0] = 'x; wr_csr[1] = 'x; wr_dat[0] = 'x; wr_dat[1] = 'x;
    wr_c[0] = -1; wr_c[1] = -1;
    @(negedge clk);
    miss_i = 1'b1; miss_addr_i = va; ptbr_i = pt;
    while (!fin && c < 400) begin
      @(negedge clk);
      c++;
      wb_ack_i = 1'b0; wb_err_i = 1'b0; cpu_csr_we_i = 1'b0; wb_dat_i = $urandom;
      if (wb_stb_o) begin
        stb_n++;
        if (first_stb < 0) begin first_stb = c; seen_adr = wb_adr_o; end
        if (stb_n == delay + 1 && mode != M_NONE) begin
          wb_ack_i = (mode == M_ACK || mode == M_BOTH);
          wb_err_i = (mode == M_ERR || mode == M_BOTH);
          wb_dat_i = pte;
          ack_c    = c;
        end
      end
      if (c > ack_c && ack_c > 0 && stalls > 0) begin
        cpu_csr_we_i = 1'b1;
        stalls--;
      end
      #1;
      if (tlb_csr_we_o && cpu_csr_we_i) overlap++;
      if (tlb_csr_we_o) begin
        if (nwr < 2) begin wr_csr[nwr] = 32'(tlb_csr_o); wr_dat[nwr] = tlb_csr_data_o; wr_c[nwr] = c; end
        nwr++;
      end
      if (done_o)  begin n_done++;  done_c  = c; fin = 1'b1; end
      if (fault_o) begin n_fault++; fault_c = c; fin = 1'b1; end
    end
    cpu_csr_we_i = 1'b0;
    check({tag, " finished"}, 32'(fin), 32'd1);
    exp_adr = {pt[31:2], 2'b00} + ((va >> OFF) << 2);
    ok = (mode == M_ACK) && pte[0];
    check({tag, " stb_start"}, 32'(first_stb), 32'd1);
    check({tag, " adr"}, seen_adr, exp_adr);
    check({tag, " fault_addr"}, fault_addr_o, va);
    check({tag, " overlap"}, 32'(overlap), 32'd0);
    if (ok) begin
      check({tag, " nwr"}, 32'(nwr), 32'd2);
      check({tag, " stb_len"}, 32'(stb_n), 32'(delay + 1));
      check({tag, " csr0"}, wr_csr[0], CSR_V);
      check({tag, " dat0"}, wr_dat[0], va & 32'hFFFF_F000);
      check({tag, " t0"}, 32'(wr_c[0]), 32'(ack_c + 1 + stall));
      check({tag, " csr1"}, wr_csr[1], CSR_P);
      check({tag, " dat1"}, wr_dat[1], pte & 32'hFFFF_F000);
      check({tag, " t1"}, 32'(wr_c[1]), 32'(wr_c[0] + 1));
      check({tag, " t_done"}, 32'(done_c), 32'(wr_c[1] + 1));
      check({tag, " n_fault"}, 32'(n_fault), 32'd0);
    end else begin
      check({tag, " nwr"}, 32'(nwr), 32'd0);
      check({tag, " n_done"}, 32'(n_done), 32'd0);
      check({tag, " n_fault"}, 32'(n_fault), 32'd1);
      if (mode == M_NONE) begin
        check({tag, " stb_len"}, 32'(stb_n), 32'(TMO));
        check({tag, " t_fault"}, 32'(fault_c), 32'(first_stb + TMO));
      end else begin
        check({tag, " stb_len"}, 32'(stb_n), 32'(delay + 1));
        check({tag, " t_fault"}, 32'(fault_c), 32'(ack_c + 1));
      end
    end
    if (!keep_miss) begin
      miss_i = 1'b0;
      repeat (2) @(negedge clk);
      check({tag, " idle"}, 32'(busy_o), 32'd0);
    end
  endtask

  initial begin
    int busy_n;
    rst_i = 1'b1; miss_i = 1'b0; miss_addr_i = '0; ptbr_i = '0;
    cpu_csr_we_i = 1'b0; wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    #1;
    check("rst cyc", 32'(wb_cyc_o), 32'd0);
    check("rst stb", 32'(wb_stb_o), 32'd0);
    check("rst busy", 32'(busy_o), 32'd0);
    check("rst done_fault", 32'({done_o, fault_o, tlb_csr_we_o}), 32'd0);
    check("rst adr", wb_adr_o, 32'd0);
    check("rst csr", 32'(tlb_csr_o), 32'd0);
    check("rst csr_data", tlb_csr_data_o, 32'd0);
    check("rst fault_addr", fault_addr_o, 32'd0);
    check("sel", 32'(wb_sel_o), 32'hF);
    repeat (2) @(negedge clk);
    rst_i = 1'b0;

    run_walk("valid",   32'h0001_2345, 32'h4000_0000, 32'h8765_4001, M_ACK,  2, 0, 1'b0);
    run_walk("invalid", 32'h0001_2345, 32'h4000_0000, 32'h8765_4000, M_ACK,  2, 0, 1'b0);
    run_walk("err",     32'h0001_2345, 32'h4000_0000, 32'h8765_4001, M_ERR,  1, 0, 1'b0);
    run_walk("both",    32'h0abc_d123, 32'h4000_0000, 32'h8765_4001, M_BOTH, 0, 0, 1'b0);
    run_walk("timeout", 32'h0001_2345, 32'h4000_0000, 32'h8765_4001, M_NONE, 0, 0, 1'b0);
    run_walk("stall",   32'h0001_2345, 32'h4000_0000, 32'h8765_4001, M_ACK,  0, 3, 1'b0);
    run_walk("wrap",    32'hFFFF_FFFF, 32'hFFFF_F003, 32'h1234_5FFF, M_ACK,  1, 0, 1'b0);

    run_walk("held", 32'h7000_1000, 32'h0010_0000, 32'h0002_0001, M_ACK, 0, 0, 1'b1);
    busy_n = 0;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (busy_o) busy_n++;
    end
    check("held no_rewalk", 32'(busy_n), 32'd0);
    miss_i = 1'b0;
    run_walk("rearm", 32'h7000_1000, 32'h0010_0000, 32'h0002_0001, M_ACK, 0, 0, 1'b0);

    @(negedge clk);
    miss_i = 1'b1; miss_addr_i = 32'h5555_5000; ptbr_i = 32'h2000_0000;
    repeat (4) @(negedge clk);
    check("midrst stb_before", 32'(wb_stb_o), 32'd1);
    #1 rst_i = 1'b1;
    #1;
    check("midrst cyc", 32'(wb_cyc_o), 32'd0);
    check("midrst stb", 32'(wb_stb_o), 32'd0);
    check("midrst busy", 32'(busy_o), 32'd0);
    check("midrst fault_addr", fault_addr_o, 32'd0);
    miss_i = 1'b0;
    #1 rst_i = 1'b0;
    run_walk("postrst", 32'h5555_5000, 32'h2000_0000, 32'hCAFE_B001, M_ACK, 3, 1, 1'b0);

    for (int i = 0; i < 16; i++) begin
      int r, m;
      logic [31:0] pte;
      r = $urandom_range(0, 9);
      m = (r < 6) ? M_ACK : (r < 8) ? M_ERR : M_BOTH;
      pte = $urandom;
      if (r < 5) pte[0] = 1'b1;
      run_walk($sformatf("rnd%0d", i), $urandom, $urandom, pte, m,
               $urandom_range(0, 4), $urandom_range(0, 3), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
